serial_digit_adder: RTL and testbench
=====================================

Name: serial_digit_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. Processes a WIDTH-bit operand pair DIGIT bits per clock through one DIGIT-bit ripple-carry slice.
- The carry is held in a register between cycles.
- Gives a wide adder at the area cost of a narrow one, for datapaths that can tolerate WIDTH/DIGIT cycles of latency.
- Uses a start/busy/done handshake, adds a subtract mode, and reports carry/borrow and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle (width of the ripple slice); 1 <= DIGIT <= WIDTH.
- Derived constant, not a parameter: NDIG = WIDTH/DIGIT, the number of cycles per operation.

Ports:
- clk  input  1  single system clock; everything is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0: a+b+c_in; 1: a-b (c_in ignored). Captured at start.
- a  input  WIDTH  operand A (unsigned or two's complement). Captured at start.
- b  input  WIDTH  operand B. Captured at start.
- c_in  input  1  carry-in for add mode. Captured at start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: sum, c_out and ovf are valid.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- c_out  output  1  carry out of bit WIDTH-1. In sub mode, 1 means no borrow (a >= b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE, digit counter to 0.
  - busy=0, done=0, sum=0, c_out=0, ovf=0.
  - Reset mid-operation aborts it; no done is produced, and the partial sum is cleared.
- FSM states: IDLE and RUN.
- IDLE, start=1 at edge T:
  - Latch opa=a and opb = sub ? ~b : b.
  - Carry register = sub ? 1 : c_in; digit counter = 0.
  - Clear sum; go to RUN. busy=1 from T+1.
- RUN, each edge, with i = counter:
  - Add slice i: {cy, s} = opa[i] + opb[i] + carry.
  - Write s into sum[(i+1)*DIGIT-1 : i*DIGIT]; carry <= cy; counter <= i+1.
  - When i = NDIG-1:
    - c_out <= cy.
    - ovf <= (carry into bit WIDTH-1) ^ cy, taken inside the slice.
    - done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge T gives done=1 and valid results during the cycle after edge T+NDIG. Throughput is one operation per NDIG cycles.
- The done pulse is exactly one cycle. sum/c_out/ovf stay stable until the next accepted start.
- start while busy=1 is ignored; inputs are not re-sampled.
- start=1 in the same cycle that done=1 is accepted (busy is already 0). Back-to-back operations therefore have no gap.
- Input changes after capture do not affect the operation in progress.
- DIGIT = WIDTH (NDIG=1): single-cycle RUN; done follows 1 cycle after start.
- Counter width: $clog2(NDIG), minimum 1. The counter never exceeds NDIG-1.
- No X on outputs after the first reset.

Decomposition:
- Shared package serial_adder_pkg:
  - Operation encoding constants OP_ADD=0 and OP_SUB=1.
  - FSM state encoding IDLE=0, RUN=1.
  - Function for NDIG and the counter width.
- One natural sub-module, digit_slice_adder (parameter DIGIT):
  - Combinational DIGIT-bit ripple chain of 1-bit full adders.
  - Outputs sum, carry-out, and the carry into its MSB (used for ovf).
- The top level holds the FSM, operand registers, carry register and result assembly.

Test Plan (WIDTH=16, DIGIT=4, NDIG=4):
- Reset, then idle 3 cycles -> busy=0, done=0, sum=0, c_out=0, ovf=0.
- Add: a=0x00C8, b=0x0022, c_in=0, start at T -> busy=1 for cycles T+1..T+4; done=1 only after T+4; sum=0x00EA, c_out=0, ovf=0.
- Add with carry/overflow:
  - a=0xFFFE, b=0x001E, c_in=1 -> sum=0x001D, c_out=1, ovf=0.
  - a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x007B, b=0x00FF, sub=1 -> sum=0xFF7C, c_out=0 (borrow), ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
- Handshake:
  - start re-asserted with new operands while busy -> ignored, first result unchanged.
  - start held high on the done cycle -> second operation accepted, done again 4 cycles later.
- Reset mid-operation: assert rst 2 cycles after start -> no done pulse, all outputs 0; a new start then completes normally with correct sum.

Source files
------------

// File: rtl/serial_digit_adder_pkg.sv
// serial_digit_adder_pkg: shared encodings and sizing helpers for the digit-serial adder
package serial_adder_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction
   function automatic int cnt_w(input int width, input int digit);
      return (width / digit > 1) ? $clog2(width / digit) : 1;
   endfunction
endpackage

// File: rtl/serial_digit_adder_if.sv
// serial_digit_adder_if: start/busy/done handshake plus operands and results
interface serial_digit_adder_if #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, ovf);
   modport slave (input start, sub, a, b, c_in, output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/serial_digit_adder_slice.sv
// digit_slice_adder: combinational DIGIT-bit ripple-carry slice exposing the carry into its MSB
module digit_slice_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);
   logic [DIGIT:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: WIDTH-bit add/subtract computed DIGIT bits per clock through one ripple slice
module serial_digit_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                clk,
   input logic                rst,
   serial_digit_adder_if.slave bus
);
   localparam int NDIG = ndig(WIDTH, DIGIT);
   localparam int CW   = cnt_w(WIDTH, DIGIT);

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa, opb, sum_r;
   logic             carry, c_out_r, ovf_r, done_r;
   logic [DIGIT-1:0] s;
   logic             cy, c_msb, last;

   assign last = cnt == CW'(NDIG - 1);

   digit_slice_adder #(.DIGIT(DIGIT)) u_slice (
      .a     (opa[int'(cnt)*DIGIT +: DIGIT]),
      .b     (opb[int'(cnt)*DIGIT +: DIGIT]),
      .ci    (carry),
      .s     (s),
      .co    (cy),
      .c_msb (c_msb)
   );

   // next state: IDLE waits for start, RUN leaves after the last digit
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // datapath: capture operands on start, then one digit per cycle into the result
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         opa     <= '0;
         opb     <= '0;
         carry   <= 1'b0;
         sum_r   <= '0;
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == IDLE && bus.start) begin
            opa   <= bus.a;
            opb   <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry <= (bus.sub == OP_SUB) ? 1'b1 : bus.c_in;
            cnt   <= '0;
            sum_r <= '0;
         end else if (state == RUN) begin
            sum_r[int'(cnt)*DIGIT +: DIGIT] <= s;
            carry <= cy;
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) begin
               c_out_r <= cy;
               ovf_r   <= c_msb ^ cy;
               done_r  <= 1'b1;
            end
         end
      end
   end

   assign bus.busy  = state == RUN;
   assign bus.done  = done_r;
   assign bus.sum   = sum_r;
   assign bus.c_out = c_out_r;
   assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder: directed and random checks of the digit-serial adder against an arithmetic model
module tb_serial_digit_adder;
   localparam int W = 16;
   localparam int D = 4;
   localparam int N = W / D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_digit_adder_if #(.WIDTH(W), .DIGIT(D)) bus ();
   serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                        output logic [W-1:0] r, output logic c, output logic o);
      logic [W:0]   t;
      logic [W-1:0] bb;
      bb = s ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + (W+1)'(s ? 1'b1 : ci);
      r  = t[W-1:0];
      c  = t[W];
      o  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
   endtask

   task automatic launch(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci);
      bus.a = a; bus.b = b; bus.sub = s; bus.c_in = ci; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int k0);
      int k;
      k = k0;
      while (!bus.done && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_latency"}, 32'(k), 32'(N));
      chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_res(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
      chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
   endtask

   task automatic dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                      input logic [W-1:0] es, input logic ec, input logic eo);
      launch(tag, a, b, s, ci);
      wait_done(tag, 0);
      check_res(tag, es, ec, eo);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, 32'(bus.sum), 32'(es));
   endtask

   initial begin
      logic [W-1:0] ra, rb, es;
      logic         rs, rc, ec, eo;
      int           bad;
      bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      check_res("rst", 16'h0000, 1'b0, 1'b0);

      dir("add", 16'h00C8, 16'h0022, 1'b0, 1'b0, 16'h00EA, 1'b0, 1'b0);
      dir("addc", 16'hFFFE, 16'h001E, 1'b0, 1'b1, 16'h001D, 1'b1, 1'b0);
      dir("addv", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      dir("subb", 16'h007B, 16'h00FF, 1'b1, 1'b0, 16'hFF7C, 1'b0, 1'b0);
      dir("subv", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      launch("ign", 16'h1234, 16'h0101, 1'b0, 1'b0);
      bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ign", 1);
      check_res("ign", 16'h1335, 1'b0, 1'b0);
      @(negedge clk);

      launch("b2b1", 16'h0100, 16'h0200, 1'b0, 1'b1);
      wait_done("b2b1", 0);
      check_res("b2b1", 16'h0301, 1'b0, 1'b0);
      launch("b2b2", 16'h5000, 16'h3000, 1'b0, 1'b0);
      wait_done("b2b2", 0);
      check_res("b2b2", 16'h8000, 1'b0, 1'b1);
      @(negedge clk);

      launch("mid", 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_done", 32'(bus.done), 32'd0);
      check_res("mid", 16'h0000, 1'b0, 1'b0);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) bad = 1;
      end
      chk("mid_no_done", 32'(bad), 32'd0);
      dir("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         model(ra, rb, rs, rc, es, ec, eo);
         launch("rnd", ra, rb, rs, rc);
         bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom); bus.c_in = 1'($urandom);
         wait_done("rnd", 0);
         check_res("rnd", es, ec, eo);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
